// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding scheduler for a 5-stage RV32I pipeline: shadow rd tracking, load-use and RAW
// stall sequencing, registered forward selects. Optional counters behind HAZ_PERF_CNT_EN.
module hazard_fwd_ctrl #(
  parameter bit          FORW_DEFAULT = 1'b1,
  parameter int unsigned LU_STALL_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       forw_mode_wr,
  input  logic       forw_mode_in,
  input  logic       id_valid,
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_flush,
  output logic       stall_fe,
  output logic       bubble_ex,
  output logic       isForw_ON,
  output logic [1:0] forwA,
  output logic [1:0] forwB
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIImm   = 7'b0010011;
  localparam logic [6:0] OpILoad  = 7'b0000011;
  localparam logic [6:0] OpSType  = 7'b0100011;
  localparam logic [6:0] OpBType  = 7'b1100011;
  localparam logic [6:0] OpIJalr  = 7'b1100111;
  localparam logic [6:0] OpJJal   = 7'b1101111;
  localparam logic [6:0] OpULui   = 7'b0110111;
  localparam logic [6:0] OpUAuipc = 7'b0010111;

  localparam logic [1:0] LuInit = 2'(LU_STALL_CYC - 1);

  typedef enum logic [1:0] {StRun, StLuStall, StRawStall} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mode_q;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d, sel_a, sel_b;

  // Only the EX entry keeps is_load: it is the sole stage a load-use hazard is checked against.
  logic       ex_v_q, mem_v_q, wb_v_q, ex_ld_q;
  logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;

  logic use_rs1, use_rs2, wr_rd;
  logic a1, a2;
  logic hit1_ex, hit1_mem, hit1_wb, hit2_ex, hit2_mem, hit2_wb;
  logic lu_haz, raw_haz, stall_req, advance;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    case (id_op)
      OpRType:          {use_rs1, use_rs2, wr_rd} = 3'b111;
      OpIImm, OpILoad:  {use_rs1, use_rs2, wr_rd} = 3'b101;
      OpSType, OpBType: {use_rs1, use_rs2, wr_rd} = 3'b110;
      OpIJalr:          {use_rs1, use_rs2, wr_rd} = 3'b101;
      OpJJal, OpULui, OpUAuipc: {use_rs1, use_rs2, wr_rd} = 3'b001;
      default:          {use_rs1, use_rs2, wr_rd} = 3'b000;
    endcase
  end

  assign a1 = id_valid && use_rs1 && (id_rs1 != 5'd0);
  assign a2 = id_valid && use_rs2 && (id_rs2 != 5'd0);

  assign hit1_ex  = a1 && ex_v_q  && (ex_rd_q  == id_rs1);
  assign hit1_mem = a1 && mem_v_q && (mem_rd_q == id_rs1);
  assign hit1_wb  = a1 && wb_v_q  && (wb_rd_q  == id_rs1);
  assign hit2_ex  = a2 && ex_v_q  && (ex_rd_q  == id_rs2);
  assign hit2_mem = a2 && mem_v_q && (mem_rd_q == id_rs2);
  assign hit2_wb  = a2 && wb_v_q  && (wb_rd_q  == id_rs2);

  assign lu_haz  = mode_q && ex_ld_q && (hit1_ex || hit2_ex);
  assign raw_haz = !mode_q && (hit1_ex || hit1_mem || hit1_wb || hit2_ex || hit2_mem || hit2_wb);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_req = 1'b0;
    if (ex_flush) begin
      state_d = StRun;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu_haz) begin
            stall_req = 1'b1;
            state_d   = StLuStall;
            cnt_d     = LuInit;
          end else if (raw_haz) begin
            stall_req = 1'b1;
            state_d   = StRawStall;
          end
        end
        StLuStall: begin
          if (mode_q && cnt_q != 2'd0) begin
            stall_req = 1'b1;
            cnt_d     = cnt_q - 2'd1;
          end else if (lu_haz) begin
            stall_req = 1'b1;
          end else if (raw_haz) begin
            stall_req = 1'b1;
            state_d   = StRawStall;
            cnt_d     = 2'd0;
          end else begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end
        end
        StRawStall: begin
          if (raw_haz) begin
            stall_req = 1'b1;
          end else if (lu_haz) begin
            stall_req = 1'b1;
            state_d   = StLuStall;
            cnt_d     = LuInit;
          end else begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  assign advance   = !stall_req && !ex_flush;
  assign stall_fe  = stall_req;
  assign bubble_ex = stall_req || ex_flush;

  // The EX match wins: it holds the youngest value of the register.
  assign sel_a   = hit1_ex ? 2'b01 : (hit1_mem ? 2'b10 : 2'b00);
  assign sel_b   = hit2_ex ? 2'b01 : (hit2_mem ? 2'b10 : 2'b00);
  assign fwd_a_d = (advance && mode_q) ? sel_a : 2'b00;
  assign fwd_b_d = (advance && mode_q) ? sel_b : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      cnt_q    <= 2'd0;
      mode_q   <= FORW_DEFAULT;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      ex_v_q   <= 1'b0;
      mem_v_q  <= 1'b0;
      wb_v_q   <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= 5'd0;
      mem_rd_q <= 5'd0;
      wb_rd_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (forw_mode_wr) mode_q <= forw_mode_in;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      ex_v_q   <= advance && id_valid && wr_rd && (id_rd != 5'd0);
      ex_ld_q  <= (id_op == OpILoad);
      ex_rd_q  <= id_rd;
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      wb_v_q   <= mem_v_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

  assign isForw_ON = mode_q;
  assign forwA     = fwd_a_q;
  assign forwB     = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_req && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ex_flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
